mca_feeder: RTL and testbench
=============================

# mca_feeder

Front end for the multi-clock FIR adder tree (`mca_single_as`). It receives the serial control-bit stream from the CBADC and keeps the K-deep control-bit window (`S_matrix`) that the adder tree reads. It also holds the coefficient bank (`H_matrix`) and paces `start` so the window is stable for a whole multi-clock addition. It captures the finished `sample` and presents it with a valid strobe.

## Interface
- `K`, 256: window length / number of taps; multiple of `MCA_NUM_ADDITIONS`.
- `WIDTH_COEFFICIENT`, 32: coefficient and sample width, max 32.
- `MCA_NUM_ADDITIONS`, 16: cycles per multi-clock addition; also the busy period after each `start`.
- `RESULT_LATENCY`, 34: cycles from `start` to a valid `sample_in`; ≥ 1.

Ports:
- `clk`  in  1: single clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous flush.
- `ctrl_bit`  in  1: incoming control bit.
- `ctrl_valid`  in  1: `ctrl_bit` valid.
- `ctrl_ready`  out  1: block accepts `ctrl_bit` this cycle.
- `coef_we`  in  1: coefficient write strobe.
- `coef_addr`  in  $clog2(K): tap index.
- `coef_data`  in  WIDTH_COEFFICIENT: signed coefficient.
- `S_matrix`  out  1 x [K-1:0]: control-bit window; [0] is the newest bit.
- `H_matrix`  out  signed WIDTH_COEFFICIENT x [K-1:0]: coefficient bank.
- `start`  out  1: one-cycle pulse to the adder tree.
- `sample_in`  in  signed WIDTH_COEFFICIENT: `sample` from the adder tree.
- `sample_out`  out  signed WIDTH_COEFFICIENT: captured result.
- `sample_valid`  out  1: one-cycle strobe with `sample_out`.

## Operation
- States:
  - FILL: after reset or `clear`.
  - RUN: window full, idle.
  - BUSY: addition in flight.
- Input handshake: a bit is accepted when `ctrl_valid && ctrl_ready`.
  - On accept: `S_matrix` shifts up by one (`S[i] <= S[i-1]`, `S[0] <= ctrl_bit`) and `S[K-1]` is discarded.
- FILL:
  - `ctrl_ready` = 1; `start` is never asserted.
  - A fill counter counts accepts.
  - On the K-th accept, go to RUN. That accept does not trigger `start`.
- RUN:
  - `ctrl_ready` = 1.
  - An accept in cycle t shifts the window, asserts `start` in t+1 and enters BUSY at t+1.
- BUSY:
  - `ctrl_ready` = 0 for exactly `MCA_NUM_ADDITIONS` cycles (t+1 .. t+MCA_NUM_ADDITIONS).
  - `S_matrix` and `H_matrix` hold stable during BUSY.
  - Return to RUN at t+MCA_NUM_ADDITIONS+1.
- Result tracking:
  - Each `start` pushes a token into a `RESULT_LATENCY`-deep shift register, so overlapping in-flight tokens are allowed.
  - When a token exits, `sample_in` is registered into `sample_out` and `sample_valid` pulses one cycle.
  - `sample_out` holds its value until the next capture.
- Coefficient writes:
  - Applied only in FILL or RUN (`H_matrix[coef_addr] <= coef_data` next edge).
  - `coef_we` in BUSY is ignored, with no buffering.
  - An out-of-range `coef_addr` (≥ K) is ignored.
- `clear`:
  - Takes priority over an accept in the same cycle.
  - Zeroes `S_matrix`, the fill counter, the busy counter and all tokens.
  - Returns to FILL next cycle; `H_matrix` is kept.
  - `start` and `sample_valid` are 0 from the following cycle on, including for flushed in-flight tokens.

## Timing
- Reset values (asynchronous, `resetn` = 0):
  - state FILL; `S_matrix` all 0; `H_matrix` all 0.
  - `ctrl_ready` 1; `start` 0; `sample_out` 0; `sample_valid` 0.
- Reset mid-BUSY aborts immediately; no stale `sample_valid` follows.
- `ctrl_ready` is a registered function of state.
- `start` is registered.
- Latencies:
  - accept → `start`: 1 cycle.
  - `start` → `sample_valid`: `RESULT_LATENCY` + 1 cycles (one capture register).
- Maximum throughput: one bit per `MCA_NUM_ADDITIONS` + 1 cycles in RUN.
- Fill phase: one bit per cycle.
- `ctrl_valid` asserted during BUSY: the bit is held off by backpressure and never lost or duplicated.

## Test plan
- Reset, then push K = 256 bits back-to-back with `ctrl_valid` = 1. Required response:
  - `ctrl_ready` stays 1.
  - No `start`.
  - `S_matrix[0]` = last bit; `S_matrix[255]` = first bit.
- Push the 257th bit at cycle t. Required response:
  - `start` = 1 only at t+1.
  - `ctrl_ready` = 0 for cycles t+1..t+16, then 1 at t+17.
  - A held `ctrl_valid` is accepted at t+17.
- Drive `sample_in` = 32'hFFFF_FF85 (-123) at the token-exit cycle. Required response:
  - `sample_valid` pulses at `start` + 35 for one cycle only.
  - `sample_out` = -123 and holds afterwards.
- `coef_we` with addr 5, data 7 in RUN → `H_matrix[5]` = 7. The same write in BUSY → no change.
- Assert `clear` in the cycle of an accept. Required response:
  - The bit is not shifted in.
  - `S_matrix` = 0 and the block returns to FILL.
  - No `sample_valid` within the next 40 cycles.
  - `H_matrix` is unchanged.
- Assert `resetn` = 0 mid-BUSY → all outputs at their reset values asynchronously; re-fill works normally afterwards.

Source files
------------

// File: rtl/mca_feeder_if.sv
// Bus between the CBADC control-bit source, the coefficient loader, the
// mca_feeder front end and the multi-clock FIR adder tree.
interface mca_feeder_if #(
  parameter int K                 = 256,
  parameter int WIDTH_COEFFICIENT = 32
);
  localparam int AW = (K > 1) ? $clog2(K) : 1;

  logic                                ctrl_bit;
  logic                                ctrl_valid;
  logic                                ctrl_ready;
  logic                                coef_we;
  logic [AW-1:0]                       coef_addr;
  logic signed [WIDTH_COEFFICIENT-1:0] coef_data;
  logic [K-1:0]                        S_matrix;
  logic signed [WIDTH_COEFFICIENT-1:0] H_matrix [K];
  logic                                start;
  logic signed [WIDTH_COEFFICIENT-1:0] sample_in;
  logic signed [WIDTH_COEFFICIENT-1:0] sample_out;
  logic                                sample_valid;

  modport master (
    output ctrl_bit, ctrl_valid, coef_we, coef_addr, coef_data, sample_in,
    input  ctrl_ready, S_matrix, H_matrix, start, sample_out, sample_valid
  );

  modport slave (
    input  ctrl_bit, ctrl_valid, coef_we, coef_addr, coef_data, sample_in,
    output ctrl_ready, S_matrix, H_matrix, start, sample_out, sample_valid
  );
endinterface

// File: rtl/mca_feeder.sv
// Front end of the multi-clock FIR adder tree: keeps the K-deep control-bit
// window and coefficient bank, paces start, and captures the finished sample.
module mca_feeder #(
  parameter int K                 = 256,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int MCA_NUM_ADDITIONS = 16,
  parameter int RESULT_LATENCY    = 34
) (
  input logic         clk,
  input logic         resetn,
  input logic         clear,
  mca_feeder_if.slave bus
);
  localparam int AW = (K > 1) ? $clog2(K) : 1;
  localparam int BW = $clog2(MCA_NUM_ADDITIONS + 1);

  typedef enum logic [1:0] {FILL, RUN, BUSY} state_t;

  state_t                  state;
  logic [AW-1:0]           fill_cnt;
  logic [BW-1:0]           busy_cnt;
  logic [RESULT_LATENCY-1:0] tokens;
  logic                    accept;

  assign accept = bus.ctrl_valid && bus.ctrl_ready;

  // Each start launches a token; the token leaving the delay line marks the
  // cycle in which the adder tree's sample is valid and gets captured.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= FILL;
      fill_cnt         <= '0;
      busy_cnt         <= '0;
      tokens           <= '0;
      bus.S_matrix     <= '0;
      bus.ctrl_ready   <= 1'b1;
      bus.start        <= 1'b0;
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
    end else if (clear) begin
      state            <= FILL;
      fill_cnt         <= '0;
      busy_cnt         <= '0;
      tokens           <= '0;
      bus.S_matrix     <= '0;
      bus.ctrl_ready   <= 1'b1;
      bus.start        <= 1'b0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.start        <= 1'b0;
      tokens[0]        <= bus.start;
      for (int i = 1; i < RESULT_LATENCY; i++) begin
        tokens[i] <= tokens[i-1];
      end
      bus.sample_valid <= tokens[RESULT_LATENCY-1];
      if (tokens[RESULT_LATENCY-1]) begin
        bus.sample_out <= bus.sample_in;
      end
      if (accept) begin
        bus.S_matrix <= {bus.S_matrix[K-2:0], bus.ctrl_bit};
      end

      case (state)
        FILL: begin
          if (accept) begin
            if (fill_cnt == AW'(K - 1)) begin
              state <= RUN;
            end else begin
              fill_cnt <= fill_cnt + AW'(1);
            end
          end
        end
        RUN: begin
          if (accept) begin
            state          <= BUSY;
            bus.start      <= 1'b1;
            bus.ctrl_ready <= 1'b0;
            busy_cnt       <= '0;
          end
        end
        BUSY: begin
          // Window must stay frozen for the whole multi-clock addition.
          if (busy_cnt == BW'(MCA_NUM_ADDITIONS - 1)) begin
            state          <= RUN;
            bus.ctrl_ready <= 1'b1;
            busy_cnt       <= '0;
          end else begin
            busy_cnt <= busy_cnt + BW'(1);
          end
        end
        default: begin
          state          <= FILL;
          bus.ctrl_ready <= 1'b1;
        end
      endcase
    end
  end

  // Coefficient writes land only while no addition is reading the bank.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < K; i++) begin
        bus.H_matrix[i] <= '0;
      end
    end else if (bus.coef_we && (state != BUSY) && (32'(bus.coef_addr) < 32'(K))) begin
      bus.H_matrix[bus.coef_addr] <= bus.coef_data;
    end
  end
endmodule

// File: tb/tb_mca_feeder.sv
// Randomized and directed bench for mca_feeder, checked each cycle against a
// time-based reference model of window, pacing, result and coefficient rules.
module tb_mca_feeder;
  localparam int K   = 256;
  localparam int W   = 32;
  localparam int NUM = 16;
  localparam int LAT = 34;
  localparam int AW  = $clog2(K);

  logic clk = 1'b0;
  logic resetn;
  logic clear;

  always #5 clk = ~clk;

  mca_feeder_if #(.K(K), .WIDTH_COEFFICIENT(W)) bus ();

  mca_feeder #(
    .K(K), .WIDTH_COEFFICIENT(W), .MCA_NUM_ADDITIONS(NUM), .RESULT_LATENCY(LAT)
  ) dut (
    .clk(clk), .resetn(resetn), .clear(clear), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: accepted bits since the last flush, fill count, cycle of the last
  // start-triggering accept, and the cycles at which results get captured.
  bit                  hist[$];
  int                  nacc;
  int                  run_acc;
  int                  cap_q[$];
  logic                exp_valid;
  logic signed [W-1:0] exp_out;
  logic signed [W-1:0] exp_h [K];
  logic                hold_sample = 1'b0;
  logic signed [W-1:0] held_value  = '0;

  function automatic bit model_busy();
    return (cyc >= run_acc + 1) && (cyc <= run_acc + NUM);
  endfunction

  task automatic model_reset();
    hist.delete();
    cap_q.delete();
    nacc      = 0;
    run_acc   = -1000;
    exp_valid = 1'b0;
    exp_out   = '0;
    for (int i = 0; i < K; i++) exp_h[i] = '0;
  endtask

  task automatic check_output(input string tag, input logic [K-1:0] observed,
                              input logic [K-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_coefs(input string tag);
    int bad = 0;
    for (int i = 0; i < K; i++) if (bus.H_matrix[i] !== exp_h[i]) bad++;
    check_output(tag, bad, 0);
  endtask

  task automatic check_cycle();
    logic [K-1:0] exp_s = '0;
    for (int i = 0; i < hist.size() && i < K; i++) exp_s[i] = hist[hist.size() - 1 - i];
    check_output("ctrl_ready", bus.ctrl_ready, !model_busy());
    check_output("start", bus.start, cyc == run_acc + 1);
    check_output("sample_valid", bus.sample_valid, exp_valid);
    check_output("sample_out", bus.sample_out, exp_out);
    check_output("s_matrix", bus.S_matrix, exp_s);
  endtask

  task automatic model_edge();
    bit busy = model_busy();
    bit st   = (cyc == run_acc + 1);
    if (bus.coef_we && !busy && int'(bus.coef_addr) < K) exp_h[bus.coef_addr] = bus.coef_data;
    if (clear) begin
      hist.delete();
      cap_q.delete();
      nacc      = 0;
      run_acc   = -1000;
      exp_valid = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (cap_q.size() > 0 && cap_q[0] == cyc) begin
        void'(cap_q.pop_front());
        exp_valid = 1'b1;
        exp_out   = bus.sample_in;
      end
      if (st) cap_q.push_back(cyc + LAT);
      if (bus.ctrl_valid && !busy) begin
        hist.push_back(bus.ctrl_bit);
        if (hist.size() > K) void'(hist.pop_front());
        if (nacc >= K) run_acc = cyc;
        else nacc++;
      end
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic b, input logic c,
                                input logic we, input int addr, input logic [W-1:0] data);
    bus.ctrl_valid = v;
    bus.ctrl_bit   = b;
    clear          = c;
    bus.coef_we    = we;
    bus.coef_addr  = AW'(addr);
    bus.coef_data  = data;
    bus.sample_in  = hold_sample ? held_value : W'($urandom);
    check_cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill_window();
    for (int i = 0; i < K; i++) apply_stimulus(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
  endtask

  initial begin
    bit first_bit, last_bit, b;
    int t, nvalid;

    resetn         = 1'b0;
    clear          = 1'b0;
    bus.ctrl_valid = 1'b0;
    bus.ctrl_bit   = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_data  = '0;
    bus.sample_in  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    $display("[TB] reset released, filling window");
    check_coefs("reset_coefs");

    for (int i = 0; i < K; i++) begin
      b = 1'($urandom_range(0, 1));
      if (i == 0) first_bit = b;
      last_bit = b;
      apply_stimulus(1, b, 0, 0, 0, 0);
    end
    check_output("fill_newest", bus.S_matrix[0], last_bit);
    check_output("fill_oldest", bus.S_matrix[K-1], first_bit);

    // 257th bit with ctrl_valid held through the busy period
    hold_sample = 1'b1;
    held_value  = 32'hFFFF_FF85;
    t = cyc;
    for (int k = 0; k <= NUM + 1; k++) begin
      check_output("start_pace", bus.start, (k == 1));
      check_output("ready_pace", bus.ctrl_ready, (k == 0) || (k == NUM + 1));
      apply_stimulus(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
    end
    for (int k = 0; k < 60; k++) begin
      check_output("valid_at_start_plus_35", bus.sample_valid,
                   (cyc == t + 1 + LAT + 1) || (cyc == t + NUM + 2 + LAT + 1));
      apply_stimulus(0, 0, 0, 0, 0, 0);
    end
    check_output("sample_hold", bus.sample_out, held_value);
    hold_sample = 1'b0;

    $display("[TB] coefficient writes in RUN and BUSY");
    apply_stimulus(0, 0, 0, 1, 5, 7);
    check_output("coef_run", bus.H_matrix[5], 7);
    apply_stimulus(1, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 5, 99);
    idle(3);
    check_output("coef_busy_ignored", bus.H_matrix[5], 7);
    idle(20);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 800; k++) begin
      apply_stimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 9) < 2),
                     int'($urandom_range(0, K - 1)), $urandom);
    end
    check_coefs("coef_random");

    $display("[TB] clear coincident with accept");
    apply_stimulus(0, 0, 1, 0, 0, 0);
    fill_window();
    apply_stimulus(1, 1, 0, 0, 0, 0);
    idle(NUM + 1);
    apply_stimulus(1, 1, 1, 0, 0, 0);
    check_output("clear_s_zero", bus.S_matrix, '0);
    check_output("clear_ready", bus.ctrl_ready, 1);
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.sample_valid) nvalid++;
      apply_stimulus(0, 0, 0, 0, 0, 0);
    end
    check_output("no_valid_after_clear", nvalid, 0);
    check_coefs("coef_after_clear");

    $display("[TB] asynchronous reset mid-busy");
    fill_window();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    idle(3);
    bus.ctrl_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check_output("rst_ready", bus.ctrl_ready, 1);
    check_output("rst_start", bus.start, 0);
    check_output("rst_valid", bus.sample_valid, 0);
    check_output("rst_sample_out", bus.sample_out, 0);
    check_output("rst_s_matrix", bus.S_matrix, '0);
    model_reset();
    check_coefs("rst_coefs");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc += 2;
    fill_window();
    apply_stimulus(1, 1, 0, 0, 0, 0);
    idle(60);
    check_coefs("coef_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
